ibex_xif_rf_wr_arbiter: RTL and testbench
=========================================

# ibex_xif_rf_wr_arbiter

Write-port arbiter and hazard scoreboard for the Ibex register file's single write port (W1), shared between core writeback and the XIF coprocessor result interface. Core writeback has priority. Accepted coprocessor results are held in a one-entry buffer and written when the port is free. A starvation counter forces a core writeback stall after a bounded wait. An optional scoreboard tracks registers with outstanding offloaded writes and flags read and write hazards to the ID stage.

## Interface
Parameters:
- RV32E, 0, 16 GPRs when 1; ADDR_WIDTH = RV32E ? 4 : 5
- DataWidth, 32, register width
- MaxStall, 4, cycles a buffered result may wait before the core is stalled (≥1)

Ports:
- clk_i  in  1  clock; sole clock
- rst_ni  in  1  synchronous, active-low reset
- rf_we_wb_i / rf_waddr_wb_i / rf_wdata_wb_i  in  1/5/DataWidth  core writeback request
- stall_wb_o  out  1  core must hold its writeback this cycle
- result_valid_i / result_ready_o  in/out  1/1  XIF result handshake
- result_we_i / result_rd_i / result_data_i  in  1/5/DataWidth  XIF result payload
- issue_valid_i / issue_we_i / issue_rd_i  in  1/1/5  offload accepted that will write rd
- raddr_a_i / raddr_b_i  in  5/5  ID-stage read addresses
- pending_a_o / pending_b_o  out  1/1  read operand has an outstanding coprocessor write
- we_a_o / waddr_a_o / wdata_a_o  out  1/5/DataWidth  to register file W1
- err_o  out  1  one-cycle protocol error pulse

## Operation
- FSM states: IDLE (buffer empty), HOLD (buffer full), FORCE (core stalled, buffer drains).
- result_ready_o = IDLE | FORCE | (HOLD & !rf_we_wb_i). It is forced to 0 while rst_ni is low.
- Accept means result_valid_i & result_ready_o.
  - If result_we_i = 1 and rd ≠ 0 and rd < 2^ADDR_WIDTH, the payload loads the buffer and the next state is HOLD.
  - Otherwise the result is dropped and the scoreboard bit is cleared. An out-of-range rd also pulses err_o.
- W1 mux:
  - FORCE: buffer is written; rf_we_wb_i is ignored.
  - HOLD & !rf_we_wb_i: buffer is written.
  - Otherwise: the core writeback passes through unchanged.
- HOLD, buffer written: the scoreboard bit for the buffered rd clears. Next state is HOLD if a new result is accepted in the same cycle, else IDLE. wait_cnt resets to 0.
- HOLD, core writes: wait_cnt increments. When wait_cnt = MaxStall-1, the next state is FORCE.
- FORCE: stall_wb_o = 1 for exactly one cycle. The buffer is written. Next state is IDLE, or HOLD on a simultaneous accept.
- Scoreboard:
  - Set: issue_valid_i & issue_we_i & issue_rd_i ≠ 0 sets bit[issue_rd_i].
  - Clear: on buffer write or dropped result.
  - Set and clear of the same register in one cycle: set wins. Bit 0 is never set.
- pending_a_o = sb[raddr_a_i], pending_b_o = sb[raddr_b_i]. Both are combinational.
- err_o pulses when:
  - a result is accepted for a register whose scoreboard bit is clear, or
  - rf_we_wb_i targets a pending register (WAW).

## Timing
- Reset values: state IDLE, buffer 0, wait_cnt 0, scoreboard 0. Resulting outputs: we_a_o reflects only rf_we_wb_i, stall_wb_o 0, err_o 0, pending_* 0.
- Result accept to we_a_o: 1 cycle minimum, MaxStall+1 cycles maximum.
- Sustained throughput is one result per cycle while the core is idle.
- Core writeback is combinational passthrough, zero added latency.
- wait_cnt width is $clog2(MaxStall+1) and it never wraps.
- Reset asserted mid-HOLD discards the buffer. No write occurs on the cycle reset is sampled.
- stall_wb_o and rf_we_wb_i high together: the core writeback is not written that cycle. The core re-presents it the following cycle.

## Configuration
- IBEX_XIF_RF_SCOREBOARD_EN defined: scoreboard, pending_a/b_o and the err_o hazard checks are present.
- Undefined: pending_a/b_o and err_o are tied 0. issue_* are unused, sunk to an unused_* signal. Arbitration is unchanged.

## Structure
- ibex_xif_pkg holds:
  - arbiter state enum rf_arb_state_e {ARB_IDLE, ARB_HOLD, ARB_FORCE}
  - struct rf_wr_t {waddr, wdata}
- Sub-module ibex_xif_rf_scoreboard: 2^ADDR_WIDTH-bit bitmap with set/clear ports and two read ports. It is instantiated only under the macro.

## Test plan
- Core idle; result rd=5, data 0xDEADBEEF accepted at cycle 0 → we_a_o=1, waddr_a_o=5, wdata 0xDEADBEEF at cycle 1; state returns to IDLE.
- Core writes every cycle; result rd=7 buffered with MaxStall=4 → result_ready_o=0 for the stall cycles, stall_wb_o=1 in exactly one cycle, waddr_a_o=7 that cycle, wait_cnt back to 0.
- Back-to-back results rd=1,2,3 with core idle → one write per cycle on cycles 1,2,3; result_ready_o stays 1.
- Issue rd=9, then read raddr_a_i=9 → pending_a_o=1 until result rd=9 written; next cycle pending_a_o=0. Result rd=10 never issued → err_o pulse (macro on), err_o=0 (macro off).
- Result rd=0 or result_we_i=0 → accepted, no W1 write, scoreboard bit cleared; RV32E=1 with rd=17 → dropped, err_o pulse.
- rst_ni low in HOLD → next cycle IDLE, buffer 0, no write, pending outputs 0, result_ready_o=0 during reset.

Source files
------------

// File: rtl/ibex_xif_pkg.sv
// ibex_xif_pkg: shared state and payload types for the XIF register-file write arbiter
package ibex_xif_pkg;
  localparam int unsigned RegAddrW = 5;
  localparam int unsigned MaxDataW = 64;
  typedef enum logic [1:0] {ARB_IDLE, ARB_HOLD, ARB_FORCE} rf_arb_state_e;
  typedef struct packed {
    logic [RegAddrW-1:0] waddr;
    logic [MaxDataW-1:0] wdata;
  } rf_wr_t;
endpackage

// File: rtl/ibex_xif_rf_scoreboard.sv
// ibex_xif_rf_scoreboard: bitmap of registers awaiting an offloaded coprocessor write
module ibex_xif_rf_scoreboard
  import ibex_xif_pkg::*;
#(
  parameter int unsigned AddrW = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set,
  input  logic [RegAddrW-1:0] set_addr,
  input  logic                clr_a,
  input  logic [RegAddrW-1:0] clr_a_addr,
  input  logic                clr_b,
  input  logic [RegAddrW-1:0] clr_b_addr,
  input  logic [RegAddrW-1:0] raddr_a,
  input  logic [RegAddrW-1:0] raddr_b,
  output logic                rdata_a,
  output logic                rdata_b,
  output logic [31:0]         bits
);
  localparam int unsigned N = 1 << AddrW;
  logic [N-1:0] sb;
  logic [N-1:0] set_mask, clr_mask;
  // addresses beyond the register file truncate to an empty mask
  function automatic logic [N-1:0] dec(input logic en, input logic [RegAddrW-1:0] a);
    return en ? N'(32'(1) << a) : '0;
  endfunction
  assign set_mask = dec(set & (set_addr != '0), set_addr);
  assign clr_mask = dec(clr_a, clr_a_addr) | dec(clr_b, clr_b_addr);
  always_ff @(posedge clk) begin
    if (!rst_n) sb <= '0;
    else sb <= (sb & ~clr_mask) | set_mask;
  end
  assign bits = 32'(sb);
  assign rdata_a = bits[raddr_a];
  assign rdata_b = bits[raddr_b];
endmodule

// File: rtl/ibex_xif_rf_wr_arbiter.sv
// ibex_xif_rf_wr_arbiter: shares RF write port W1 between core writeback and XIF results
// IBEX_XIF_RF_SCOREBOARD_EN adds the pending-write scoreboard and hazard error reporting.
module ibex_xif_rf_wr_arbiter
  import ibex_xif_pkg::*;
#(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned MaxStall  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rf_we_wb_i,
  input  logic [4:0]           rf_waddr_wb_i,
  input  logic [DataWidth-1:0] rf_wdata_wb_i,
  output logic                 stall_wb_o,
  input  logic                 result_valid_i,
  output logic                 result_ready_o,
  input  logic                 result_we_i,
  input  logic [4:0]           result_rd_i,
  input  logic [DataWidth-1:0] result_data_i,
  input  logic                 issue_valid_i,
  input  logic                 issue_we_i,
  input  logic [4:0]           issue_rd_i,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  output logic                 pending_a_o,
  output logic                 pending_b_o,
  output logic                 we_a_o,
  output logic [4:0]           waddr_a_o,
  output logic [DataWidth-1:0] wdata_a_o,
  output logic                 err_o
);
  localparam int unsigned AddrW = RV32E ? 4 : 5;
  localparam int unsigned CntW  = $clog2(MaxStall + 1);
  rf_arb_state_e   state_q, state_d;
  rf_wr_t          buf_q;
  logic [CntW-1:0] wait_q, wait_d;
  logic            accept, in_range, load, drop, buf_wr;
  logic            unused_data;
  assign result_ready_o = rst_ni & ((state_q != ARB_HOLD) | ~rf_we_wb_i);
  assign accept   = result_valid_i & result_ready_o;
  assign in_range = {1'b0, result_rd_i} < 6'(1 << AddrW);
  assign load     = accept & result_we_i & (result_rd_i != '0) & in_range;
  assign drop     = accept & ~load;
  // the buffer never writes while reset is sampled, so a mid-HOLD reset discards it
  assign buf_wr     = rst_ni & ((state_q == ARB_FORCE) | ((state_q == ARB_HOLD) & ~rf_we_wb_i));
  assign stall_wb_o = rst_ni & (state_q == ARB_FORCE);
  assign we_a_o     = buf_wr | rf_we_wb_i;
  assign waddr_a_o  = buf_wr ? buf_q.waddr : rf_waddr_wb_i;
  assign wdata_a_o  = buf_wr ? buf_q.wdata[DataWidth-1:0] : rf_wdata_wb_i;
  assign unused_data = ^buf_q.wdata;
  always_comb begin
    state_d = load ? ARB_HOLD : ARB_IDLE;
    wait_d  = '0;
    if (state_q == ARB_HOLD && rf_we_wb_i) begin
      state_d = (wait_q == CntW'(MaxStall - 1)) ? ARB_FORCE : ARB_HOLD;
      wait_d  = wait_q + 1'b1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      buf_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (load) buf_q <= '{waddr: result_rd_i, wdata: MaxDataW'(result_data_i)};
    end
  end
`ifdef IBEX_XIF_RF_SCOREBOARD_EN
  logic [31:0] sb_bits;
  ibex_xif_rf_scoreboard #(.AddrW(AddrW)) u_sb (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .set       (issue_valid_i & issue_we_i),
    .set_addr  (issue_rd_i),
    .clr_a     (buf_wr),
    .clr_a_addr(buf_q.waddr),
    .clr_b     (drop),
    .clr_b_addr(result_rd_i),
    .raddr_a   (raddr_a_i),
    .raddr_b   (raddr_b_i),
    .rdata_a   (pending_a_o),
    .rdata_b   (pending_b_o),
    .bits      (sb_bits)
  );
  assign err_o = rst_ni & ((load & ~sb_bits[result_rd_i]) | (accept & ~in_range) |
                           (rf_we_wb_i & sb_bits[rf_waddr_wb_i]));
`else
  logic unused_issue;
  assign unused_issue = ^{issue_valid_i, issue_we_i, issue_rd_i, raddr_a_i, raddr_b_i, drop};
  assign pending_a_o = 1'b0;
  assign pending_b_o = 1'b0;
  assign err_o       = 1'b0;
`endif
endmodule

// File: tb/tb_ibex_xif_rf_wr_arbiter.sv
// tb_ibex_xif_rf_wr_arbiter: vector table, directed RV32E case and randomized model checks
`timescale 1ns/1ps
module tb_ibex_xif_rf_wr_arbiter;
`ifdef IBEX_XIF_RF_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif
  localparam int MS = 4;
  logic clk = 1'b0;
  logic rst_n, core_we, rvalid, rwe, ivalid, iwe;
  logic [4:0] core_addr, rd, ird, ra, rb;
  logic [31:0] core_data, rdata;
  logic stall, rready, pa, pb, we, err;
  logic [4:0] waddr;
  logic [31:0] wdata;
  logic e_stall, e_rready, e_pa, e_pb, e_we, e_err;
  logic [4:0] e_waddr;
  logic [31:0] e_wdata;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  ibex_xif_rf_wr_arbiter #(.RV32E(1'b0), .DataWidth(32), .MaxStall(MS)) dut (
    .clk_i(clk), .rst_ni(rst_n), .rf_we_wb_i(core_we), .rf_waddr_wb_i(core_addr),
    .rf_wdata_wb_i(core_data), .stall_wb_o(stall), .result_valid_i(rvalid),
    .result_ready_o(rready), .result_we_i(rwe), .result_rd_i(rd), .result_data_i(rdata),
    .issue_valid_i(ivalid), .issue_we_i(iwe), .issue_rd_i(ird), .raddr_a_i(ra),
    .raddr_b_i(rb), .pending_a_o(pa), .pending_b_o(pb), .we_a_o(we), .waddr_a_o(waddr),
    .wdata_a_o(wdata), .err_o(err));
  ibex_xif_rf_wr_arbiter #(.RV32E(1'b1), .DataWidth(32), .MaxStall(MS)) dut_e (
    .clk_i(clk), .rst_ni(rst_n), .rf_we_wb_i(core_we), .rf_waddr_wb_i(core_addr),
    .rf_wdata_wb_i(core_data), .stall_wb_o(e_stall), .result_valid_i(rvalid),
    .result_ready_o(e_rready), .result_we_i(rwe), .result_rd_i(rd), .result_data_i(rdata),
    .issue_valid_i(ivalid), .issue_we_i(iwe), .issue_rd_i(ird), .raddr_a_i(ra),
    .raddr_b_i(rb), .pending_a_o(e_pa), .pending_b_o(e_pb), .we_a_o(e_we), .waddr_a_o(e_waddr),
    .wdata_a_o(e_wdata), .err_o(e_err));

  typedef struct {
    bit rst; bit cwe; logic [4:0] caddr; logic [31:0] cdata;
    bit rv; bit rwe; logic [4:0] rd; logic [31:0] rdat;
    logic [4:0] ird; logic [4:0] ra;
    bit x_ready; bit x_stall; bit x_we; logic [4:0] x_addr; logic [31:0] x_data; bit x_pa; bit x_err;
  } vec_t;
  vec_t tbl[$];

  typedef struct { logic [4:0] addr; logic [31:0] data; } ent_t;
  ent_t mq[$];
  int waited;
  bit sbm[32];

  function automatic logic [42:0] pack(input logic r, s, w, input logic [4:0] a,
                                       input logic [31:0] d, input logic p, q, e);
    return {r, s, w, w ? a : 5'd0, w ? d : 32'd0, p, q, e};
  endfunction

  task automatic cmp(input string name, input logic [42:0] got, input logic [42:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got rdy/stall/we/addr/data/pa/pb/err=%h required %h", name, got, exp);
    end
  endtask

  task automatic cmp1(input string name, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b required %b", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    rst_n = 1'b1; core_we = 1'b0; core_addr = '0; core_data = '0;
    rvalid = 1'b0; rwe = 1'b0; rd = '0; rdata = '0;
    ivalid = 1'b0; iwe = 1'b0; ird = '0; ra = '0; rb = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    //          rst  cwe  caddr  cdata         rv   rwe  rd     rdat            ird    ra     rdy  stl  we   addr   data            pa   err
    tbl.push_back('{1'b0,1'b1,5'd3, 32'h11,        1'b1,1'b1,5'd5, 32'h0,          5'd0,  5'd0,  1'b0,1'b0,1'b1,5'd3, 32'h11,         1'b0,1'b0});
    tbl.push_back('{1'b1,1'b0,5'd0, 32'h0,         1'b0,1'b0,5'd0, 32'h0,          5'd5,  5'd5,  1'b1,1'b0,1'b0,5'd0, 32'h0,          1'b0,1'b0});
    tbl.push_back('{1'b1,1'b0,5'd0, 32'h0,         1'b1,1'b1,5'd5, 32'hDEADBEEF,   5'd0,  5'd5,  1'b1,1'b0,1'b0,5'd0, 32'h0,          1'b1,1'b0});
    tbl.push_back('{1'b1,1'b0,5'd0, 32'h0,         1'b0,1'b0,5'd0, 32'h0,          5'd0,  5'd5,  1'b1,1'b0,1'b1,5'd5, 32'hDEADBEEF,   1'b1,1'b0});
    tbl.push_back('{1'b1,1'b0,5'd0, 32'h0,         1'b0,1'b0,5'd0, 32'h0,          5'd7,  5'd5,  1'b1,1'b0,1'b0,5'd0, 32'h0,          1'b0,1'b0});
    tbl.push_back('{1'b1,1'b0,5'd0, 32'h0,         1'b1,1'b1,5'd7, 32'h77,         5'd0,  5'd7,  1'b1,1'b0,1'b0,5'd0, 32'h0,          1'b1,1'b0});
    tbl.push_back('{1'b1,1'b1,5'd2, 32'h22,        1'b1,1'b1,5'd9, 32'h0,          5'd0,  5'd7,  1'b0,1'b0,1'b1,5'd2, 32'h22,         1'b1,1'b0});
    tbl.push_back('{1'b1,1'b1,5'd3, 32'h33,        1'b0,1'b0,5'd0, 32'h0,          5'd0,  5'd7,  1'b0,1'b0,1'b1,5'd3, 32'h33,         1'b1,1'b0});
    tbl.push_back('{1'b1,1'b1,5'd4, 32'h44,        1'b0,1'b0,5'd0, 32'h0,          5'd0,  5'd7,  1'b0,1'b0,1'b1,5'd4, 32'h44,         1'b1,1'b0});
    tbl.push_back('{1'b1,1'b1,5'd6, 32'h66,        1'b0,1'b0,5'd0, 32'h0,          5'd0,  5'd7,  1'b0,1'b0,1'b1,5'd6, 32'h66,         1'b1,1'b0});
    tbl.push_back('{1'b1,1'b1,5'd6, 32'h66,        1'b0,1'b0,5'd0, 32'h0,          5'd0,  5'd7,  1'b1,1'b1,1'b1,5'd7, 32'h77,         1'b1,1'b0});
    tbl.push_back('{1'b1,1'b1,5'd6, 32'h66,        1'b0,1'b0,5'd0, 32'h0,          5'd1,  5'd7,  1'b1,1'b0,1'b1,5'd6, 32'h66,         1'b0,1'b0});
    tbl.push_back('{1'b1,1'b0,5'd0, 32'h0,         1'b1,1'b1,5'd1, 32'hA1,         5'd2,  5'd1,  1'b1,1'b0,1'b0,5'd0, 32'h0,          1'b1,1'b0});
    tbl.push_back('{1'b1,1'b0,5'd0, 32'h0,         1'b1,1'b1,5'd2, 32'hA2,         5'd3,  5'd1,  1'b1,1'b0,1'b1,5'd1, 32'hA1,         1'b1,1'b0});
    tbl.push_back('{1'b1,1'b0,5'd0, 32'h0,         1'b1,1'b1,5'd3, 32'hA3,         5'd0,  5'd1,  1'b1,1'b0,1'b1,5'd2, 32'hA2,         1'b0,1'b0});
    tbl.push_back('{1'b1,1'b0,5'd0, 32'h0,         1'b0,1'b0,5'd0, 32'h0,          5'd0,  5'd3,  1'b1,1'b0,1'b1,5'd3, 32'hA3,         1'b1,1'b0});
    tbl.push_back('{1'b1,1'b0,5'd0, 32'h0,         1'b0,1'b0,5'd0, 32'h0,          5'd0,  5'd3,  1'b1,1'b0,1'b0,5'd0, 32'h0,          1'b0,1'b0});
    tbl.push_back('{1'b1,1'b0,5'd0, 32'h0,         1'b1,1'b1,5'd10,32'h10,         5'd0,  5'd0,  1'b1,1'b0,1'b0,5'd0, 32'h0,          1'b0,1'b1});
    tbl.push_back('{1'b1,1'b0,5'd0, 32'h0,         1'b0,1'b0,5'd0, 32'h0,          5'd0,  5'd0,  1'b1,1'b0,1'b1,5'd10,32'h10,         1'b0,1'b0});
    tbl.push_back('{1'b1,1'b0,5'd0, 32'h0,         1'b0,1'b0,5'd0, 32'h0,          5'd12, 5'd12, 1'b1,1'b0,1'b0,5'd0, 32'h0,          1'b0,1'b0});
    tbl.push_back('{1'b1,1'b0,5'd0, 32'h0,         1'b1,1'b0,5'd12,32'h5,          5'd0,  5'd12, 1'b1,1'b0,1'b0,5'd0, 32'h0,          1'b1,1'b0});
    tbl.push_back('{1'b1,1'b0,5'd0, 32'h0,         1'b0,1'b0,5'd0, 32'h0,          5'd0,  5'd12, 1'b1,1'b0,1'b0,5'd0, 32'h0,          1'b0,1'b0});
    tbl.push_back('{1'b1,1'b0,5'd0, 32'h0,         1'b1,1'b1,5'd0, 32'h5,          5'd0,  5'd0,  1'b1,1'b0,1'b0,5'd0, 32'h0,          1'b0,1'b0});
    tbl.push_back('{1'b1,1'b0,5'd0, 32'h0,         1'b0,1'b0,5'd0, 32'h0,          5'd0,  5'd0,  1'b1,1'b0,1'b0,5'd0, 32'h0,          1'b0,1'b0});
    tbl.push_back('{1'b1,1'b0,5'd0, 32'h0,         1'b0,1'b0,5'd0, 32'h0,          5'd8,  5'd0,  1'b1,1'b0,1'b0,5'd0, 32'h0,          1'b0,1'b0});
    tbl.push_back('{1'b1,1'b1,5'd8, 32'h88,        1'b0,1'b0,5'd0, 32'h0,          5'd0,  5'd8,  1'b1,1'b0,1'b1,5'd8, 32'h88,         1'b1,1'b1});
    tbl.push_back('{1'b1,1'b0,5'd0, 32'h0,         1'b1,1'b1,5'd8, 32'h99,         5'd0,  5'd8,  1'b1,1'b0,1'b0,5'd0, 32'h0,          1'b1,1'b0});
    tbl.push_back('{1'b0,1'b0,5'd0, 32'h0,         1'b0,1'b0,5'd0, 32'h0,          5'd0,  5'd0,  1'b0,1'b0,1'b0,5'd0, 32'h0,          1'b0,1'b0});
    tbl.push_back('{1'b1,1'b0,5'd0, 32'h0,         1'b0,1'b0,5'd0, 32'h0,          5'd0,  5'd8,  1'b1,1'b0,1'b0,5'd0, 32'h0,          1'b0,1'b0});
    foreach (tbl[i]) begin
      rst_n = tbl[i].rst; core_we = tbl[i].cwe; core_addr = tbl[i].caddr; core_data = tbl[i].cdata;
      rvalid = tbl[i].rv; rwe = tbl[i].rwe; rd = tbl[i].rd; rdata = tbl[i].rdat;
      ivalid = tbl[i].ird != 5'd0; iwe = 1'b1; ird = tbl[i].ird; ra = tbl[i].ra; rb = '0;
      #1;
      cmp($sformatf("vec%0d", i), pack(rready, stall, we, waddr, wdata, pa, pb, err),
          pack(tbl[i].x_ready, tbl[i].x_stall, tbl[i].x_we, tbl[i].x_addr, tbl[i].x_data,
               SB & tbl[i].x_pa, 1'b0, SB & tbl[i].x_err));
      tick();
    end

    // out-of-range rd on an RV32E instance is dropped; the full-size instance buffers it
    idle_inputs();
    rst_n = 1'b0;
    tick();
    idle_inputs();
    rvalid = 1'b1; rwe = 1'b1; rd = 5'd17; rdata = 32'h17;
    #1;
    cmp1("rv32e_ready", e_rready, 1'b1);
    cmp1("rv32e_err", e_err, SB);
    cmp1("rv32i_err17", err, SB);
    tick();
    idle_inputs();
    #1;
    cmp1("rv32e_no_write", e_we, 1'b0);
    cmp("rv32i_write17", pack(rready, stall, we, waddr, wdata, pa, pb, err),
        pack(1'b1, 1'b0, 1'b1, 5'd17, 32'h17, 1'b0, 1'b0, 1'b0));
    tick();

    idle_inputs();
    rst_n = 1'b0;
    tick();
    mq.delete();
    waited = 0;
    foreach (sbm[i]) sbm[i] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      int busy;
      bit have, forcing, bw, acc, ld, x_ready, x_stall, x_we, x_err;
      logic [4:0] x_addr;
      logic [31:0] x_data;
      busy = (c / 250) % 3 == 0 ? 10 : ((c / 250) % 3 == 1 ? 50 : 96);
      rst_n = $urandom_range(0, 299) != 0;
      core_we = $urandom_range(0, 99) < busy;
      core_addr = 5'($urandom_range(0, 7));
      core_data = $urandom;
      rvalid = $urandom_range(0, 1) == 1;
      rwe = $urandom_range(0, 9) != 0;
      rd = 5'($urandom_range(0, 7));
      rdata = $urandom;
      ivalid = $urandom_range(0, 4) < 2;
      iwe = $urandom_range(0, 4) != 0;
      ird = 5'($urandom_range(0, 7));
      ra = 5'($urandom_range(0, 7));
      rb = 5'($urandom_range(0, 7));
      #1;
      have = mq.size() != 0;
      forcing = rst_n && have && waited >= MS;
      bw = rst_n && have && (forcing || !core_we);
      x_ready = rst_n && (!have || bw);
      x_stall = forcing;
      x_we = bw || core_we;
      x_addr = bw ? mq[0].addr : core_addr;
      x_data = bw ? mq[0].data : core_data;
      acc = rvalid && x_ready;
      ld = acc && rwe && rd != 5'd0;
      x_err = SB && rst_n && ((ld && !sbm[rd]) || (core_we && sbm[core_addr]));
      cmp($sformatf("rand%0d", c), pack(rready, stall, we, waddr, wdata, pa, pb, err),
          pack(x_ready, x_stall, x_we, x_addr, x_data, SB && sbm[ra], SB && sbm[rb], x_err));
      tick();
      if (!rst_n) begin
        mq.delete();
        waited = 0;
        foreach (sbm[i]) sbm[i] = 1'b0;
      end else begin
        if (bw) begin
          sbm[mq[0].addr] = 1'b0;
          void'(mq.pop_front());
          waited = 0;
        end else if (have) waited++;
        if (acc && !ld) sbm[rd] = 1'b0;
        if (ld) mq.push_back('{addr: rd, data: rdata});
        if (ivalid && iwe && ird != 5'd0) sbm[ird] = 1'b1;
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
